// File: rtl/weight_stream_dispatcher_if.sv
// Weight AXI-Stream bundle between the weight source and the dispatcher.
//   master : drives tvalid/tdata/tlast, samples tready
//   slave  : samples tvalid/tdata/tlast, drives tready
interface weight_stream_dispatcher_if #(
   parameter int unsigned AXIS_DATA_WIDTH = 64
);
   logic                       s_axis_w_tvalid;
   logic                       s_axis_w_tready;
   logic [AXIS_DATA_WIDTH-1:0] s_axis_w_tdata;
   logic                       s_axis_w_tlast;

   modport master (
      output s_axis_w_tvalid,
      output s_axis_w_tdata,
      output s_axis_w_tlast,
      input  s_axis_w_tready
   );

   modport slave (
      input  s_axis_w_tvalid,
      input  s_axis_w_tdata,
      input  s_axis_w_tlast,
      output s_axis_w_tready
   );
endinterface

// File: rtl/weight_stream_dispatcher.sv
// Assembles AXIS_DATA_WIDTH-bit stream beats into LINE_WIDTH-bit weight lines
// and writes each line into the weight BRAM of one selected compute core.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_load_weights     start pulse (IDLE only); i_target_layer / i_weight_base /
//                      i_num_lines are latched with it
//   axis               weight stream (slave side)
//   o_wr_en/addr/data  one-hot BRAM write strobe, address, assembled line
//   o_busy, o_done     activity flag, one-cycle completion pulse
//   o_err_tlast        sticky framing error, o_err_cfg sticky config error
module weight_stream_dispatcher #(
   parameter int unsigned AXIS_DATA_WIDTH = 64,
   parameter int unsigned NUM_TARGETS     = 5,
   parameter int unsigned LINE_WIDTH      = 1152,
   parameter int unsigned ADDR_WIDTH      = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_load_weights,
   input  logic [3:0]              i_target_layer,
   input  logic [ADDR_WIDTH-1:0]   i_weight_base,
   input  logic [ADDR_WIDTH:0]     i_num_lines,
   weight_stream_dispatcher_if.slave axis,
   output logic [NUM_TARGETS-1:0]  o_wr_en,
   output logic [ADDR_WIDTH-1:0]   o_wr_addr,
   output logic [LINE_WIDTH-1:0]   o_wr_data,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err_tlast,
   output logic                    o_err_cfg
);

   localparam int unsigned BEATS = LINE_WIDTH / AXIS_DATA_WIDTH;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LW    = ADDR_WIDTH + 1;

   // Reject line widths that are not a whole number of beats.
   if (LINE_WIDTH % AXIS_DATA_WIDTH != 0) begin : g_cfg_check
      $error("LINE_WIDTH must be a multiple of AXIS_DATA_WIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              target_q, target_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [LW-1:0]           lines_q, lines_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [LW-1:0]           line_q, line_d;
   logic [LINE_WIDTH-1:0]   buf_q, buf_d, line_w;
   logic                    tready_q, tready_d;
   logic [NUM_TARGETS-1:0]  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [LINE_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    et_q, et_d;
   logic                    ec_q, ec_d;

   logic accept, last_beat, last_line, final_beat, cfg_ok;

   assign accept     = axis.s_axis_w_tvalid && tready_q;
   assign last_beat  = (beat_q == BW'(BEATS - 1));
   assign last_line  = (line_q == lines_q - LW'(1));
   assign final_beat = last_beat && last_line;
   assign cfg_ok     = (32'(i_target_layer) < NUM_TARGETS) && (i_num_lines != '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_load_weights) state_d = cfg_ok ? S_LOAD : S_DRAIN;
         S_LOAD: begin
            if (accept) begin
               if (axis.s_axis_w_tlast && !final_beat) state_d = S_DONE;
               else if (final_beat) state_d = axis.s_axis_w_tlast ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: if (accept && axis.s_axis_w_tlast) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; status outputs follow the next state so
   // they are registered yet aligned with the state they describe.
   always_comb begin
      target_d  = target_q;
      base_d    = base_q;
      lines_d   = lines_q;
      beat_d    = beat_q;
      line_d    = line_q;
      buf_d     = buf_q;
      wr_en_d   = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      et_d      = et_q;
      ec_d      = ec_q;
      tready_d  = (state_d == S_LOAD) || (state_d == S_DRAIN);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      line_w    = buf_q;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (beat_q == BW'(k)) line_w[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = axis.s_axis_w_tdata;
      end

      case (state_q)
         S_IDLE: begin
            if (i_load_weights) begin
               target_d = i_target_layer;
               base_d   = i_weight_base;
               lines_d  = i_num_lines;
               beat_d   = '0;
               line_d   = '0;
               et_d     = 1'b0;
               ec_d     = !cfg_ok;
            end
         end
         S_LOAD: begin
            if (accept) begin
               buf_d = line_w;
               if (axis.s_axis_w_tlast && !final_beat) begin
                  // Early end of frame: partial line is dropped.
                  beat_d = '0;
                  et_d   = 1'b1;
               end else if (last_beat) begin
                  wr_en_d   = NUM_TARGETS'(1) << target_q;
                  wr_addr_d = ADDR_WIDTH'(base_q + line_q[ADDR_WIDTH-1:0]);
                  wr_data_d = line_w;
                  beat_d    = '0;
                  line_d    = line_q + LW'(1);
                  if (last_line && !axis.s_axis_w_tlast) et_d = 1'b1;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q  <= '0;
         base_q    <= '0;
         lines_q   <= '0;
         beat_q    <= '0;
         line_q    <= '0;
         buf_q     <= '0;
         tready_q  <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         et_q      <= 1'b0;
         ec_q      <= 1'b0;
      end else begin
         target_q  <= target_d;
         base_q    <= base_d;
         lines_q   <= lines_d;
         beat_q    <= beat_d;
         line_q    <= line_d;
         buf_q     <= buf_d;
         tready_q  <= tready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         et_q      <= et_d;
         ec_q      <= ec_d;
      end
   end

   assign axis.s_axis_w_tready = tready_q;
   assign o_wr_en     = wr_en_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_data   = wr_data_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_err_tlast = et_q;
   assign o_err_cfg   = ec_q;

endmodule
